// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the registered ALU.
//   - 4-bit opcode constants (OP_ADD .. OP_NOP)
//   - operation-class enum used to drive the one-hot class flags
//   - compare result constants and the divide-by-zero result
//   - op_class(): maps an opcode to its class
package alu_pkg;

   localparam logic [3:0] OP_ADD  = 4'b0000;
   localparam logic [3:0] OP_SUB  = 4'b0001;
   localparam logic [3:0] OP_MUL  = 4'b0010;
   localparam logic [3:0] OP_DIV  = 4'b0011;
   localparam logic [3:0] OP_AND  = 4'b0100;
   localparam logic [3:0] OP_OR   = 4'b0101;
   localparam logic [3:0] OP_NAND = 4'b0110;
   localparam logic [3:0] OP_NOR  = 4'b0111;
   localparam logic [3:0] OP_XOR  = 4'b1000;
   localparam logic [3:0] OP_XNOR = 4'b1001;
   localparam logic [3:0] OP_EQ   = 4'b1010;
   localparam logic [3:0] OP_GT   = 4'b1011;
   localparam logic [3:0] OP_LT   = 4'b1100;
   localparam logic [3:0] OP_SHR  = 4'b1101;
   localparam logic [3:0] OP_SHL  = 4'b1110;
   localparam logic [3:0] OP_NOP  = 4'b1111;

   typedef enum logic [2:0] {
      ClsNone,
      ClsArith,
      ClsLogic,
      ClsCmp,
      ClsShift
   } op_class_e;

   localparam int unsigned CMP_EQ_VAL = 1;
   localparam int unsigned CMP_GT_VAL = 2;
   localparam int unsigned CMP_LT_VAL = 3;

   localparam logic [15:0] DIV_BY_ZERO_VAL = 16'hFFFF;

   function automatic op_class_e op_class(input logic [3:0] op);
      op_class_e cls;
      case (op)
         OP_ADD, OP_SUB, OP_MUL, OP_DIV:                   cls = ClsArith;
         OP_AND, OP_OR, OP_NAND, OP_NOR, OP_XOR, OP_XNOR: cls = ClsLogic;
         OP_EQ, OP_GT, OP_LT:                              cls = ClsCmp;
         OP_SHR, OP_SHL:                                   cls = ClsShift;
         default:                                          cls = ClsNone;
      endcase
      return cls;
   endfunction

endpackage

// File: rtl/alu_flag_dec.sv
// alu_flag_dec: combinational decoder from opcode to the one-hot class flags.
//   alu_fun_i     opcode
//   arith_flag_o  opcode in ADD..DIV
//   logic_flag_o  opcode in AND..XNOR
//   cmp_flag_o    opcode in EQ..LT
//   shift_flag_o  opcode in SHR..SHL
// NOP raises no flag.
module alu_flag_dec
   import alu_pkg::*;
(
   input  logic [3:0] alu_fun_i,
   output logic       arith_flag_o,
   output logic       logic_flag_o,
   output logic       cmp_flag_o,
   output logic       shift_flag_o
);

   always_comb begin
      arith_flag_o = 1'b0;
      logic_flag_o = 1'b0;
      cmp_flag_o   = 1'b0;
      shift_flag_o = 1'b0;
      unique case (op_class(alu_fun_i))
         ClsArith: arith_flag_o = 1'b1;
         ClsLogic: logic_flag_o = 1'b1;
         ClsCmp:   cmp_flag_o   = 1'b1;
         ClsShift: shift_flag_o = 1'b1;
         ClsNone:  ;
      endcase
   end

endmodule

// File: rtl/alu.sv
// alu: registered 16-operation arithmetic/logic unit, latency one clock.
//   clk, rst_n   clock and asynchronous active-low reset (clears all outputs)
//   A, B         operands (unsigned)
//   ALU_FUN      operation select (see alu_pkg opcodes)
//   ALU_OUT      registered result
//   Carry_Flag   ADD carry-out / SUB borrow, 0 otherwise
//   Arith_Flag, Logic_Flag, CMP_Flag, Shift_Flag  one-hot class of registered op
//   Zero_Flag    only when ALU_ZERO_FLAG_EN is defined: result is 0 and op is not NOP
module alu
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [3:0]       ALU_FUN,
   output logic [WIDTH-1:0] ALU_OUT,
   output logic             Carry_Flag,
   output logic             Arith_Flag,
   output logic             Logic_Flag,
   output logic             CMP_Flag,
   output logic             Shift_Flag
`ifdef ALU_ZERO_FLAG_EN
   ,
   output logic             Zero_Flag
`endif
);

   logic [WIDTH-1:0] res_d, res_q;
   logic             carry_d, carry_q;
   logic             arith_d, logic_d, cmp_d, shift_d;
   logic             arith_q, logic_q, cmp_q, shift_q;

   alu_flag_dec u_flag_dec (
      .alu_fun_i    (ALU_FUN),
      .arith_flag_o (arith_d),
      .logic_flag_o (logic_d),
      .cmp_flag_o   (cmp_d),
      .shift_flag_o (shift_d)
   );

   always_comb begin
      res_d   = '0;
      carry_d = 1'b0;
      case (ALU_FUN)
         OP_ADD:  {carry_d, res_d} = {1'b0, A} + {1'b0, B};
         OP_SUB: begin
            res_d   = A - B;
            carry_d = (A < B);
         end
         OP_MUL:  res_d = A * B;  // upper product bits discarded
         OP_DIV:  res_d = (B == '0) ? WIDTH'(DIV_BY_ZERO_VAL) : A / B;
         OP_AND:  res_d = A & B;
         OP_OR:   res_d = A | B;
         OP_NAND: res_d = ~(A & B);
         OP_NOR:  res_d = ~(A | B);
         OP_XOR:  res_d = A ^ B;
         OP_XNOR: res_d = ~(A ^ B);
         OP_EQ:   res_d = (A == B) ? WIDTH'(CMP_EQ_VAL) : '0;
         OP_GT:   res_d = (A > B)  ? WIDTH'(CMP_GT_VAL) : '0;
         OP_LT:   res_d = (A < B)  ? WIDTH'(CMP_LT_VAL) : '0;
         OP_SHR:  res_d = A >> 1;
         OP_SHL:  res_d = A << 1;
         default: res_d = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res_q   <= '0;
         carry_q <= 1'b0;
         arith_q <= 1'b0;
         logic_q <= 1'b0;
         cmp_q   <= 1'b0;
         shift_q <= 1'b0;
      end else begin
         res_q   <= res_d;
         carry_q <= carry_d;
         arith_q <= arith_d;
         logic_q <= logic_d;
         cmp_q   <= cmp_d;
         shift_q <= shift_d;
      end
   end

   assign ALU_OUT    = res_q;
   assign Carry_Flag = carry_q;
   assign Arith_Flag = arith_q;
   assign Logic_Flag = logic_q;
   assign CMP_Flag   = cmp_q;
   assign Shift_Flag = shift_q;

`ifdef ALU_ZERO_FLAG_EN
   logic zero_d, zero_q;

   assign zero_d = (res_d == '0) && (ALU_FUN != OP_NOP);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         zero_q <= 1'b0;
      end else begin
         zero_q <= zero_d;
      end
   end

   assign Zero_Flag = zero_q;
`endif

endmodule

// File: tb/tb_alu.sv
// tb_alu: self-checking bench for alu (table vectors, reset sequences, random vs model).
module tb_alu;

   logic        clk;
   logic        rst_n;
   logic [15:0] a;
   logic [15:0] b;
   logic [3:0]  fun;
   logic [15:0] alu_out;
   logic        carry, arith, logic_f, cmp, shift;
`ifdef ALU_ZERO_FLAG_EN
   logic        zero;
`endif

   int total = 0;
   int bad   = 0;

   alu #(.WIDTH(16)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .A          (a),
      .B          (b),
      .ALU_FUN    (fun),
      .ALU_OUT    (alu_out),
      .Carry_Flag (carry),
      .Arith_Flag (arith),
      .Logic_Flag (logic_f),
      .CMP_Flag   (cmp),
      .Shift_Flag (shift)
`ifdef ALU_ZERO_FLAG_EN
      ,
      .Zero_Flag  (zero)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  op;
      logic [15:0] va;
      logic [15:0] vb;
      logic [15:0] exp_out;
      logic        exp_c;
      logic [3:0]  exp_f;  // {arith, logic, cmp, shift}
   } vec_t;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h required %0h", name, got, exp);
      end
   endtask

   // Reference model: derived from the operation rules with integer arithmetic.
   task automatic model(input logic [3:0] op, input logic [15:0] ma, input logic [15:0] mb,
                        output logic [15:0] r, output logic c, output logic [3:0] f);
      int unsigned ua = ma;
      int unsigned ub = mb;
      int unsigned t;
      c = 1'b0;
      case (op)
         4'd0: begin t = ua + ub; r = 16'(t % 65536); c = (t > 65535); end
         4'd1: begin r = 16'((ua + 65536 - ub) % 65536); c = (ua < ub); end
         4'd2: r = 16'((ua * ub) % 65536);
         4'd3: r = (ub == 0) ? 16'd65535 : 16'(ua / ub);
         4'd4: r = ma & mb;
         4'd5: r = ma | mb;
         4'd6: r = ~(ma & mb);
         4'd7: r = ~(ma | mb);
         4'd8: r = ma ^ mb;
         4'd9: r = ~(ma ^ mb);
         4'd10: r = (ua == ub) ? 16'd1 : 16'd0;
         4'd11: r = (ua > ub) ? 16'd2 : 16'd0;
         4'd12: r = (ua < ub) ? 16'd3 : 16'd0;
         4'd13: r = 16'(ua / 2);
         4'd14: r = 16'((ua * 2) % 65536);
         default: r = 16'd0;
      endcase
      if (op <= 4'd3)       f = 4'b1000;
      else if (op <= 4'd9)  f = 4'b0100;
      else if (op <= 4'd12) f = 4'b0010;
      else if (op <= 4'd14) f = 4'b0001;
      else                  f = 4'b0000;
   endtask

   task automatic chk_out(input string name, input logic [3:0] op, input logic [15:0] eo,
                          input logic ec, input logic [3:0] ef);
      chk({name, " out"}, 32'(alu_out), 32'(eo));
      chk({name, " carry"}, 32'(carry), 32'(ec));
      chk({name, " flags"}, 32'({arith, logic_f, cmp, shift}), 32'(ef));
`ifdef ALU_ZERO_FLAG_EN
      chk({name, " zero"}, 32'(zero), 32'((eo == 16'd0) && (op != 4'hF)));
`endif
   endtask

   task automatic chk_all_zero(input string name);
      chk({name, " out"}, 32'(alu_out), 32'd0);
      chk({name, " flags"}, 32'({carry, arith, logic_f, cmp, shift}), 32'd0);
`ifdef ALU_ZERO_FLAG_EN
      chk({name, " zero"}, 32'(zero), 32'd0);
`endif
   endtask

   vec_t vecs[$];

   initial begin
      logic [15:0] er;
      logic        ec;
      logic [3:0]  ef;
      logic [15:0] hold_out;

      vecs.push_back('{4'h0, 16'd5,     16'd6,   16'd11,    1'b0, 4'b1000});
      vecs.push_back('{4'h1, 16'd5,     16'd6,   16'hFFFF,  1'b1, 4'b1000});
      vecs.push_back('{4'h2, 16'd5,     16'd6,   16'd30,    1'b0, 4'b1000});
      vecs.push_back('{4'h3, 16'd5,     16'd6,   16'd0,     1'b0, 4'b1000});
      vecs.push_back('{4'h0, 16'hFFFF,  16'd1,   16'd0,     1'b1, 4'b1000});
      vecs.push_back('{4'h3, 16'd7,     16'd0,   16'hFFFF,  1'b0, 4'b1000});
      vecs.push_back('{4'h2, 16'd300,   16'd300, 16'h5F90,  1'b0, 4'b1000});
      vecs.push_back('{4'h4, 16'd5,     16'd6,   16'd4,     1'b0, 4'b0100});
      vecs.push_back('{4'h5, 16'd5,     16'd6,   16'd7,     1'b0, 4'b0100});
      vecs.push_back('{4'h6, 16'd5,     16'd6,   16'hFFFB,  1'b0, 4'b0100});
      vecs.push_back('{4'h7, 16'd5,     16'd6,   16'hFFF8,  1'b0, 4'b0100});
      vecs.push_back('{4'h8, 16'd5,     16'd6,   16'd3,     1'b0, 4'b0100});
      vecs.push_back('{4'h9, 16'd5,     16'd6,   16'hFFFC,  1'b0, 4'b0100});
      vecs.push_back('{4'hA, 16'd5,     16'd6,   16'd0,     1'b0, 4'b0010});
      vecs.push_back('{4'hB, 16'd5,     16'd6,   16'd0,     1'b0, 4'b0010});
      vecs.push_back('{4'hC, 16'd5,     16'd6,   16'd3,     1'b0, 4'b0010});
      vecs.push_back('{4'hA, 16'd9,     16'd9,   16'd1,     1'b0, 4'b0010});
      vecs.push_back('{4'hB, 16'd9,     16'd2,   16'd2,     1'b0, 4'b0010});
      vecs.push_back('{4'hD, 16'h8005,  16'd0,   16'h4002,  1'b0, 4'b0001});
      vecs.push_back('{4'hE, 16'h8005,  16'd0,   16'h000A,  1'b0, 4'b0001});
      vecs.push_back('{4'hF, 16'd5,     16'd6,   16'd0,     1'b0, 4'b0000});

      // Reset held from time zero: outputs must be cleared even across edges.
      rst_n = 1'b0;
      a     = 16'd5;
      b     = 16'd6;
      fun   = 4'h0;
      repeat (2) @(posedge clk);
      #1;
      chk_all_zero("reset held");

      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk_all_zero("after release no edge");
      @(posedge clk);
      #1;
      chk_out("first add", 4'h0, 16'd11, 1'b0, 4'b1000);

      // Table vectors, applied back-to-back.
      foreach (vecs[i]) begin
         a   = vecs[i].va;
         b   = vecs[i].vb;
         fun = vecs[i].op;
         @(posedge clk);
         #1;
         chk_out($sformatf("vec%0d op%0h", i, vecs[i].op), vecs[i].op, vecs[i].exp_out,
                 vecs[i].exp_c, vecs[i].exp_f);
      end

      // Sweep all 16 codes consecutively: each result must belong to the op just sampled.
      for (int k = 0; k < 16; k++) begin
         a   = 16'hA5C3;
         b   = 16'h0F0F;
         fun = 4'(k);
         model(fun, a, b, er, ec, ef);
         @(posedge clk);
         #1;
         chk_out($sformatf("sweep op%0h", k), 4'(k), er, ec, ef);
      end

      // Inputs changing between edges must not affect the registered outputs.
      a   = 16'd5;
      b   = 16'd6;
      fun = 4'h1;
      @(posedge clk);
      #1;
      hold_out = alu_out;
      chk_out("sub before glitch", 4'h1, 16'hFFFF, 1'b1, 4'b1000);
      a   = 16'd1;
      b   = 16'd1;
      fun = 4'h4;
      #2;
      chk("hold between edges out", 32'(alu_out), 32'(hold_out));
      chk("hold between edges flags", 32'({carry, arith, logic_f, cmp, shift}), 32'b11000);

      // Mid-cycle asynchronous reset clears immediately and discards the pending op.
      a   = 16'd5;
      b   = 16'd6;
      fun = 4'h1;
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk_all_zero("async reset immediate");
      @(posedge clk);
      #1;
      chk_all_zero("async reset held edge");
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk_all_zero("in-flight discarded");
      @(posedge clk);
      #1;
      chk_out("post reset sub", 4'h1, 16'hFFFF, 1'b1, 4'b1000);

      // Random back-to-back stimulus against the model.
      for (int n = 0; n < 400; n++) begin
         int unsigned mode;
         fun  = 4'($urandom_range(0, 15));
         a    = 16'($urandom);
         mode = $urandom_range(0, 7);
         case (mode)
            0: b = 16'd0;
            1: b = a;
            2: b = 16'($urandom_range(0, 15));
            default: b = 16'($urandom);
         endcase
         model(fun, a, b, er, ec, ef);
         @(posedge clk);
         #1;
         chk_out($sformatf("rand%0d op%0h a%0h b%0h", n, fun, a, b), fun, er, ec, ef);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
